// File: rtl/hazard_ctrl.sv
// Decode/execute sequencing controller: load scoreboard, load-use/limit/fence holds, redirect squash.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MAX_LOADS     = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rs1_idx_i,
  input  logic        ex_rs1_used_i,
  input  logic [4:0]  ex_rs2_idx_i,
  input  logic        ex_rs2_used_i,
  input  logic [4:0]  ex_rd_idx_i,
  input  logic        ex_rd_wr_en_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_fence_i,
  input  logic        ex_redirect_i,
  input  logic        ld_ret_valid_i,
  input  logic [4:0]  ld_ret_rd_idx_i,
  output logic        ex_hold_o,
  output logic        fetch_stall_o,
  output logic        decode_stall_o,
  output logic        fetch_squash_o,
  output logic        decode_squash_o,
  output logic [3:0]  ld_count_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] MaxLd     = 4'(MAX_LOADS);
  localparam logic [2:0] SqReload  = 3'(SQUASH_CYCLES - 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] pending_q, pending_d;
  logic [3:0]  ld_count_q, ld_count_d;

  logic [31:0] ret_mask;
  logic [31:0] pend_eff;
  logic        raw, full, fence_wait, hold;
  logic        ex_fire, redir_fire, squash;
  logic        ld_inc, ld_dec;

  // Writeback forwards same-cycle data, so a returning rd no longer blocks its reader.
  assign ret_mask   = ld_ret_valid_i ? (32'd1 << ld_ret_rd_idx_i) : 32'd0;
  assign pend_eff   = pending_q & ~ret_mask;

  assign raw        = ex_valid_i & ((ex_rs1_used_i & pend_eff[ex_rs1_idx_i]) |
                                    (ex_rs2_used_i & pend_eff[ex_rs2_idx_i]));
  assign full       = ex_valid_i & ex_mem_rd_i & (ld_count_q == MaxLd) & ~ld_ret_valid_i;
  assign fence_wait = ex_valid_i & ex_fence_i & (ld_count_q != 4'd0);
  assign hold       = ~rst_i & (raw | full | fence_wait);

  assign ex_fire    = ex_valid_i & ~hold;
  assign redir_fire = ex_fire & ex_redirect_i;
  assign squash     = ~rst_i & ((state_q == FLUSH) | redir_fire);

  assign ex_hold_o       = hold;
  assign fetch_stall_o   = hold;
  // Squash wins over stall on decode so the injected bubble is actually captured.
  assign decode_stall_o  = hold & ~squash;
  assign fetch_squash_o  = squash;
  assign decode_squash_o = squash;
  assign ld_count_o      = ld_count_q;

  always_comb begin
    pending_d = pending_q & ~ret_mask;
    if (ex_fire & ex_mem_rd_i & ex_rd_wr_en_i & (ex_rd_idx_i != 5'd0))
      pending_d = pending_d | (32'd1 << ex_rd_idx_i);
    pending_d[0] = 1'b0;
  end

  assign ld_inc = ex_fire & ex_mem_rd_i;
  assign ld_dec = ld_ret_valid_i & (ld_count_q != 4'd0);

  always_comb begin
    ld_count_d = ld_count_q;
    if (ld_inc & ~ld_dec)
      ld_count_d = ld_count_q + 4'd1;
    else if (~ld_inc & ld_dec)
      ld_count_d = ld_count_q - 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      ld_count_q <= '0;
    end else begin
      pending_q  <= pending_d;
      ld_count_q <= ld_count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (redir_fire && SQUASH_CYCLES > 1) begin
            cnt_q   <= SqReload;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (redir_fire) begin
            cnt_q <= SqReload;
          end else if (cnt_q == 3'd1) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (hold && stall_cycles_q != 32'hFFFF_FFFF)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (redir_fire && flush_count_q != 32'hFFFF_FFFF)
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MAX_LOADS=4, SQUASH_CYCLES=2).
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_rs1_used, ex_rs2_used, ex_rd_wr_en, ex_mem_rd, ex_fence, ex_redirect;
  logic [4:0]  ex_rs1_idx, ex_rs2_idx, ex_rd_idx, ld_ret_idx;
  logic        ld_ret_valid;
  logic        ex_hold, fetch_stall, decode_stall, fetch_squash, decode_squash;
  logic [3:0]  ld_count;
  logic [31:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [8:0] exp;
    bit         perf;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.MAX_LOADS(4), .SQUASH_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_rs1_idx_i(ex_rs1_idx), .ex_rs1_used_i(ex_rs1_used),
    .ex_rs2_idx_i(ex_rs2_idx), .ex_rs2_used_i(ex_rs2_used), .ex_rd_idx_i(ex_rd_idx),
    .ex_rd_wr_en_i(ex_rd_wr_en), .ex_mem_rd_i(ex_mem_rd), .ex_fence_i(ex_fence),
    .ex_redirect_i(ex_redirect), .ld_ret_valid_i(ld_ret_valid), .ld_ret_rd_idx_i(ld_ret_idx),
    .ex_hold_o(ex_hold), .fetch_stall_o(fetch_stall), .decode_stall_o(decode_stall),
    .fetch_squash_o(fetch_squash), .decode_squash_o(decode_squash), .ld_count_o(ld_count),
    .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  always #5 clk = ~clk;

  // Monitor: sample mid-cycle, compare against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [8:0] act;
      e = sb.pop_front();
      act = {ex_hold, fetch_stall, decode_stall, fetch_squash, decode_squash, ld_count};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got hold/fst/dst/fsq/dsq/cnt=%b_%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%b_%0d",
                 e.name, act[8], act[7], act[6], act[5], act[4], act[3:0],
                 e.exp[8], e.exp[7], e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
      end
      if (e.perf) begin
        total++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
          bad++;
          $display("FAIL %s_perf: got stall=%0d flush=%0d expected 0 0", e.name, stall_cycles, flush_count);
        end
      end
    end
  end

  task automatic idle();
    ex_valid = 0; ex_rs1_used = 0; ex_rs2_used = 0; ex_rd_wr_en = 0; ex_mem_rd = 0;
    ex_fence = 0; ex_redirect = 0; ex_rs1_idx = 0; ex_rs2_idx = 0; ex_rd_idx = 0;
    ld_ret_valid = 0; ld_ret_idx = 0;
  endtask

  task automatic load(input logic [4:0] rd);
    idle(); ex_valid = 1; ex_mem_rd = 1; ex_rd_wr_en = 1; ex_rd_idx = rd;
  endtask

  task automatic use1(input logic [4:0] rs);
    idle(); ex_valid = 1; ex_rs1_used = 1; ex_rs1_idx = rs;
  endtask

  task automatic ret(input logic [4:0] rd);
    ld_ret_valid = 1; ld_ret_idx = rd;
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic h, input logic sq, input logic [3:0] c,
                     input bit perf = 0);
    exp_t e;
    e.name = nm;
    e.exp  = {h, h, h & ~sq, sq, sq, c};
    e.perf = perf;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; idle();
    @(posedge clk); #1;
    cyc("reset", 0, 0, 0, 1);
    rst = 0;

    // Load-use interlock on x5
    load(5);                  cyc("lu_load", 0, 0, 0);
    use1(5);                  cyc("lu_hold0", 1, 0, 1);
    use1(5);                  cyc("lu_hold1", 1, 0, 1);
    use1(5); ret(5);          cyc("lu_ret", 0, 0, 1);
    use1(5);                  cyc("lu_after", 0, 0, 0);

    // Set/clear collision on x7
    load(7);                  cyc("col_load", 0, 0, 0);
    load(7); ret(7);          cyc("col_both", 0, 0, 1);
    idle(); ex_valid = 1; ex_rs2_used = 1; ex_rs2_idx = 7;
                              cyc("col_pend", 1, 0, 1);
    ret(7);                   cyc("col_ret", 0, 0, 1);
    idle();                   cyc("col_idle", 0, 0, 0);

    // Load limit
    load(1);                  cyc("lim_l1", 0, 0, 0);
    load(2);                  cyc("lim_l2", 0, 0, 1);
    load(3);                  cyc("lim_l3", 0, 0, 2);
    load(4);                  cyc("lim_l4", 0, 0, 3);
    load(8);                  cyc("lim_full0", 1, 0, 4);
    load(8);                  cyc("lim_full1", 1, 0, 4);
    load(8); ret(1);          cyc("lim_fire", 0, 0, 4);
    idle(); ret(2);           cyc("lim_r2", 0, 0, 4);
    idle(); ret(3);           cyc("lim_r3", 0, 0, 3);

    // Fence with two outstanding loads (x4, x8)
    idle(); ex_valid = 1; ex_fence = 1;
                              cyc("fen_wait", 1, 0, 2);
    ret(4);                   cyc("fen_r4", 1, 0, 2);
    ret(8);                   cyc("fen_r8", 1, 0, 1);
    ld_ret_valid = 0; ld_ret_idx = 0;
                              cyc("fen_fire", 0, 0, 0);
    idle();                   cyc("fen_idle", 0, 0, 0);

    // Redirect, held branch during flush, then back-to-back redirects
    load(9);                  cyc("rd_load", 0, 0, 0);
    idle(); ex_valid = 1; ex_redirect = 1;
                              cyc("rd_jump", 0, 1, 1);
    use1(9); ex_redirect = 1; cyc("rd_flush_hold", 1, 1, 1);
    use1(9); ex_redirect = 1; ret(9);
                              cyc("rd_held_fires", 0, 1, 1);
    idle(); ex_valid = 1; ex_redirect = 1;
                              cyc("rd_second", 0, 1, 0);
    idle();                   cyc("rd_ext", 0, 1, 0);
    idle();                   cyc("rd_done", 0, 0, 0);

    // Async reset mid-flush with three loads pending
    load(10);                 cyc("rs_l10", 0, 0, 0);
    load(11);                 cyc("rs_l11", 0, 0, 1);
    load(12);                 cyc("rs_l12", 0, 0, 2);
    idle(); ex_valid = 1; ex_redirect = 1;
                              cyc("rs_jump", 0, 1, 3);
    idle(); rst = 1;          cyc("rs_reset", 0, 0, 0, 1);
    rst = 0; use1(10);        cyc("rs_use10", 0, 0, 0, 1);
    idle();                   cyc("rs_idle", 0, 0, 0);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the decode/execute boundary of the Lucid64 core.
- Keeps a scoreboard of destination registers with loads in flight, and counts outstanding loads.
- From these it generates the stall and squash controls for fetch and decode, plus a hold on the execute-stage instruction.
- Handles load-use interlocks, control-flow redirect flushes and fence draining.

Parameters:
- MAX_LOADS, 4: maximum outstanding loads (1..15); issuing a further load holds execute.
- SQUASH_CYCLES, 2: cycles fetch and decode are squashed per redirect, including the redirect cycle (1..7).

Ports:
- clk_i  in  1  single clock; all state on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  valid instruction in the decode->execute register.
- ex_rs1_idx_i  in  5  rs1 index of the execute-stage instruction.
- ex_rs1_used_i  in  1  rs1 is read.
- ex_rs2_idx_i  in  5  rs2 index.
- ex_rs2_used_i  in  1  rs2 is read.
- ex_rd_idx_i  in  5  destination index.
- ex_rd_wr_en_i  in  1  instruction writes rd.
- ex_mem_rd_i  in  1  instruction is a load.
- ex_fence_i  in  1  instruction is a fence.
- ex_redirect_i  in  1  branch taken or jump resolved in execute; qualified by ex_fire.
- ld_ret_valid_i  in  1  load data written back this cycle.
- ld_ret_rd_idx_i  in  5  rd of the returning load.
- ex_hold_o  out  1  hold the execute instruction; inject a bubble downstream.
- fetch_stall_o  out  1  stall the fetch stage.
- decode_stall_o  out  1  drives decode stall_i.
- fetch_squash_o  out  1  squash the fetch output.
- decode_squash_o  out  1  drives decode squash_i.
- ld_count_o  out  4  outstanding load count.
- stall_cycles_o  out  32  performance counter; see Optional Feature.
- flush_count_o  out  32  performance counter; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to RUN; scoreboard pending[31:1] cleared; ld_count 0; squash counter 0; perf counters 0.
  - All outputs are 0 while rst_i is high.
- Definition: ex_fire = ex_valid_i & ~ex_hold_o.
- Raw hazard:
  - raw = ex_valid_i & ((ex_rs1_used_i & pend_eff[ex_rs1_idx_i]) | (ex_rs2_used_i & pend_eff[ex_rs2_idx_i])).
  - pend_eff = pending with the bit at ld_ret_rd_idx_i cleared when ld_ret_valid_i, because writeback forwards same-cycle data.
  - x0 is never pending.
- Load-limit full: full = ex_valid_i & ex_mem_rd_i & (ld_count == MAX_LOADS) & ~ld_ret_valid_i.
- Fence wait: fence_wait = ex_valid_i & ex_fence_i & (ld_count != 0). A fence proceeds in the same cycle that ld_count reads 0.
- Hold: ex_hold_o = raw | full | fence_wait (combinational).
  - Whenever ex_hold_o is 1: fetch_stall_o = 1 and decode_stall_o = 1.
- Scoreboard update on each posedge:
  - On ld_ret_valid_i, clear pending[ld_ret_rd_idx_i].
  - On ex_fire & ex_mem_rd_i & ex_rd_wr_en_i & (ex_rd_idx_i != 0), set pending[ex_rd_idx_i].
  - If set and clear hit the same index in the same cycle, set wins.
- ld_count update:
  - +1 on ex_fire & ex_mem_rd_i; -1 on ld_ret_valid_i; unchanged when both occur.
  - A return with ld_count == 0 is ignored, and ld_count stays 0.
- FSM, two states:
  - RUN: on ex_fire & ex_redirect_i, assert fetch_squash_o and decode_squash_o combinationally. If SQUASH_CYCLES > 1, load cnt = SQUASH_CYCLES-1 and go to FLUSH; otherwise stay in RUN.
  - FLUSH: both squash outputs are 1. cnt decrements each cycle; when cnt == 1, return to RUN.
  - A new qualified redirect while in FLUSH reloads cnt = SQUASH_CYCLES-1.
- Priority and interaction of squash and stall:
  - Squash dominates stall for decode: decode_stall_o is forced to 0 while decode_squash_o is 1, so the bubble is captured.
  - ex_hold_o is independent of squash.
- Redirect qualification: ex_redirect_i is ignored when not ex_fire; a held branch redirects on the cycle it fires.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- When defined:
  - stall_cycles_o increments on each cycle with ex_hold_o = 1.
  - flush_count_o increments on each qualified redirect.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When not defined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: load x5 fires (cycle 0); next instruction reads rs1 = x5 with no return.
  - Required: ex_hold_o, fetch_stall_o and decode_stall_o are 1 until ld_ret_valid_i with idx 5.
  - Required: hold drops in the return cycle, and pending[5] = 0 afterwards.
- Set/clear collision: ld_ret for x7 in the same cycle a new load to x7 fires -> pending[7] = 1; ld_count unchanged.
- Load limit with MAX_LOADS = 4:
  - Issue 4 loads to distinct rd -> ld_count_o = 4.
  - A 5th load is held; it fires in the cycle a return arrives, and ld_count_o stays 4.
- Fence: fence arrives with 2 outstanding loads -> held for 2 returns; fires in the cycle after ld_count_o reaches 0 (count reads 0).
- Redirect with SQUASH_CYCLES = 2:
  - Fired jump -> squash outputs high for exactly 2 cycles, with decode_stall_o = 0 throughout.
  - Second redirect in the FLUSH cycle -> squash extends to 3 cycles total.
- Async reset mid-FLUSH with 3 loads pending:
  - Required: all outputs drop in the same cycle, ld_count_o = 0, and a subsequent read of a previously pending rd is not held.
  - With HAZARD_CTRL_PERF_EN defined, both counters read 0 after the reset.
